vga_frame_monitor: RTL and testbench

Synthesizable frame monitor that sits on the VGA output of `TOP`, alongside the controller's `hs`/`vs`/`rdn`/`r`/`g`/`b` lines. It counts active pixels and lines per frame and computes a per-frame CRC-16 signature. It flags timing or geometry violations and reports one result per frame. The result can be used on-board or compared in simulation against a software model of the frame dump. Resolution, colour depth and channel count are parametrised.

---
 rtl/vga_mon_pkg.sv | 39 +++
 rtl/vga_mon_crc16.sv | 49 ++++
 rtl/vga_frame_monitor.sv | 197 +++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_mon_pkg
// Brief    : Shared constants, CRC-16 step function and monitor state type
//            for the VGA frame monitor.
// Revision : 1.0 - initial release
// ============================================================================
package vga_mon_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } mon_state_t;

  // Advance a non-reflected CRC-16 over the low 'width' bits of 'data',
  // most significant bit first. Words wider than 64 bits are not supported.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [63:0] data,
                                             input int          width);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      if (i < width) begin
        fb = c[15] ^ data[i];
        c  = {c[14:0], 1'b0};
        if (fb) begin
          c = c ^ CRC16_POLY;
        end
      end
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mon_crc16.sv
`default_nettype none
// ============================================================================
// Module   : vga_mon_crc16
// Brief    : CRC-16 register. 'init_i' reloads the seed, 'update_i' folds in
//            one PW-bit word; both together start a fresh CRC with that word.
// Revision : 1.0 - initial release
// ============================================================================
module vga_mon_crc16
  import vga_mon_pkg::*;
#(
  parameter int PW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          init_i,
  input  logic          update_i,
  input  logic [PW-1:0] data_i,
  output logic [15:0]   crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] crc_base;
  logic [63:0] data_ext;

  assign data_ext = 64'(data_i);

  // Seed selection first, so a word arriving with init lands in the new CRC
  always_comb begin
    crc_base = init_i ? CRC16_INIT : crc_q;
    crc_d    = crc_base;
    if (update_i) begin
      crc_d = crc16_step(crc_base, data_ext, PW);
    end
  end

  // CRC state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_monitor
// Brief    : Watches a VGA pixel stream, counts active pixels/lines, signs
//            each frame with CRC-16 and reports one result per frame.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int  H_ACTIVE = 640,
  parameter int  V_ACTIVE = 480,
  parameter int  CW       = 4,
  parameter int  N_CH     = 3,
  localparam int PW       = N_CH * CW,
  localparam int LW       = $clog2(V_ACTIVE + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pix_en,
  input  logic          vs,
  input  logic          rdn,
  input  logic [PW-1:0] pix,
  input  logic          err_clr,
  output logic          frame_valid,
  output logic          frame_ok,
  output logic [15:0]   frame_crc,
  output logic [15:0]   frame_idx,
  output logic [LW-1:0] line_cnt,
  output logic          err_hpix,
  output logic          err_vline
);

  // Pixel counter holds up to H_ACTIVE+1; the line counter saturates at
  // V_ACTIVE+1 or at its largest code if that does not fit the port width.
  localparam int            HW         = $clog2(H_ACTIVE + 2);
  localparam int            LINE_SAT_I = ((V_ACTIVE + 1) < (2 ** LW)) ?
                                         (V_ACTIVE + 1) : ((2 ** LW) - 1);
  localparam logic [HW-1:0] PIX_TGT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] PIX_SAT    = HW'(H_ACTIVE + 1);
  localparam logic [LW-1:0] LINE_TGT   = LW'(V_ACTIVE);
  localparam logic [LW-1:0] LINE_SAT   = LW'(LINE_SAT_I);

  mon_state_t    state_q, state_d;
  logic          vs_q, rdn_q;
  logic          vs_rise, rdn_rise;
  logic          accept, line_end, frame_end, frame_start;
  logic [HW-1:0] pix_cnt_q, pix_cnt_d, pix_base;
  logic [LW-1:0] lines_q, lines_d, lines_closed;
  logic          bad_q, bad_d, line_bad, frame_good;
  logic [15:0]   crc_cur;
  logic          frame_valid_q, frame_ok_q;
  logic [15:0]   frame_crc_q, frame_idx_q;
  logic [LW-1:0] line_cnt_q;
  logic          err_hpix_q, err_hpix_d, err_vline_q, err_vline_d;

  assign vs_rise  = pix_en & vs & ~vs_q;
  assign rdn_rise = pix_en & rdn & ~rdn_q;

  // Remember the last sampled vs/rdn so edges are judged per pixel sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q  <= 1'b0;
      rdn_q <= 1'b0;
    end else if (pix_en) begin
      vs_q  <= vs;
      rdn_q <= rdn;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: the first vs rise arms the monitor for good
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_rise) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a line still open (last sample displaying) closes at vs
  always_comb begin
    accept      = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        frame_start = vs_rise;
      end
      ACTIVE: begin
        accept      = pix_en & ~rdn;
        frame_end   = vs_rise;
        frame_start = vs_rise;
        line_end    = rdn_rise | (vs_rise & ~rdn_q);
      end
      default: ;
    endcase
  end

  // Counter and flag next-state: the closing frame is judged before any
  // pixel on the same sample is credited to the new frame
  always_comb begin
    line_bad     = line_end && (pix_cnt_q != PIX_TGT);
    lines_closed = lines_q;
    if (line_end && (lines_q != LINE_SAT)) begin
      lines_closed = lines_q + LW'(1);
    end
    frame_good = (lines_closed == LINE_TGT) && !bad_q && !line_bad;

    pix_base  = (line_end || frame_start) ? '0 : pix_cnt_q;
    pix_cnt_d = pix_base;
    if (accept && (pix_base != PIX_SAT)) begin
      pix_cnt_d = pix_base + HW'(1);
    end

    lines_d = frame_start ? '0 : lines_closed;
    bad_d   = frame_start ? 1'b0 : (bad_q | line_bad);

    err_hpix_d  = line_bad ? 1'b1 : (err_clr ? 1'b0 : err_hpix_q);
    err_vline_d = (frame_end && (lines_closed != LINE_TGT)) ? 1'b1 :
                  (err_clr ? 1'b0 : err_vline_q);
  end

  // Per-frame counters and the bad-line marker
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_cnt_q <= '0;
      lines_q   <= '0;
      bad_q     <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      lines_q   <= lines_d;
      bad_q     <= bad_d;
    end
  end

  // Frame result registers, updated only at frame end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_valid_q <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_crc_q   <= '0;
      frame_idx_q   <= '0;
      line_cnt_q    <= '0;
    end else begin
      frame_valid_q <= frame_end;
      if (frame_end) begin
        frame_ok_q  <= frame_good;
        frame_crc_q <= crc_cur;
        frame_idx_q <= frame_idx_q + 16'd1;
        line_cnt_q  <= lines_closed;
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_hpix_q  <= 1'b0;
      err_vline_q <= 1'b0;
    end else begin
      err_hpix_q  <= err_hpix_d;
      err_vline_q <= err_vline_d;
    end
  end

  vga_mon_crc16 #(
    .PW (PW)
  ) u_crc (
    .clk      (clk),
    .rstn     (rstn),
    .init_i   (frame_start),
    .update_i (accept),
    .data_i   (pix),
    .crc_o    (crc_cur)
  );

  assign frame_valid = frame_valid_q;
  assign frame_ok    = frame_ok_q;
  assign frame_crc   = frame_crc_q;
  assign frame_idx   = frame_idx_q;
  assign line_cnt    = line_cnt_q;
  assign err_hpix    = err_hpix_q;
  assign err_vline   = err_vline_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_monitor
// Brief    : Self-checking bench for vga_frame_monitor (4x2 geometry,
//            12-bit pixels, pix_en every 4th clock) with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_monitor;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int PW = 12;
  localparam int LW = $clog2(V + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pix_en = 1'b0;
  logic          vs = 1'b0;
  logic          rdn = 1'b1;
  logic [PW-1:0] pix = '0;
  logic          err_clr = 1'b0;
  logic          frame_valid, frame_ok, err_hpix, err_vline;
  logic [15:0]   frame_crc, frame_idx;
  logic [LW-1:0] line_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;
  logic rand_clr     = 1'b0;
  logic idx_override = 1'b0;

  vga_frame_monitor #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .CW       (4),
    .N_CH     (3)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pix_en      (pix_en),
    .vs          (vs),
    .rdn         (rdn),
    .pix         (pix),
    .err_clr     (err_clr),
    .frame_valid (frame_valid),
    .frame_ok    (frame_ok),
    .frame_crc   (frame_crc),
    .frame_idx   (frame_idx),
    .line_cnt    (line_cnt),
    .err_hpix    (err_hpix),
    .err_vline   (err_vline)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc_bits(input bit b[$]);
    logic [15:0] r;
    logic        top;
    r = 16'hFFFF;
    foreach (b[i]) begin
      top = r[15];
      r   = r << 1;
      if (top ^ b[i]) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_words(input logic [PW-1:0] w[$]);
    bit bq[$];
    foreach (w[i]) begin
      for (int k = PW - 1; k >= 0; k--) bq.push_back(w[i][k]);
    end
    return crc_bits(bq);
  endfunction

  logic          m_act = 1'b0, m_pv = 1'b0, m_pr = 1'b0, m_bad = 1'b0;
  int            m_lp = 0, m_lines = 0;
  logic [PW-1:0] m_words[$];
  logic          e_valid = 1'b0, e_ok = 1'b0, e_hpix = 1'b0, e_vline = 1'b0;
  logic [15:0]   e_crc = '0, e_idx = '0;
  int            e_lc = 0;
  logic          vr, rr, set_h, set_v;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_act = 1'b0; m_pv = 1'b0; m_pr = 1'b0; m_bad = 1'b0;
      m_lp = 0; m_lines = 0; m_words.delete();
      e_valid = 1'b0; e_ok = 1'b0; e_hpix = 1'b0; e_vline = 1'b0;
      e_crc = '0; e_idx = '0; e_lc = 0;
    end else begin
      set_h = 1'b0;
      set_v = 1'b0;
      e_valid = 1'b0;
      if (idx_override) e_idx = 16'hFFFF;
      if (pix_en) begin
        vr = vs && !m_pv;
        rr = rdn && !m_pr;
        if (!m_act) begin
          if (vr) begin
            m_act = 1'b1; m_lp = 0; m_lines = 0; m_bad = 1'b0; m_words.delete();
          end
        end else begin
          if (rr || (vr && !m_pr)) begin
            if (m_lp != H) begin m_bad = 1'b1; set_h = 1'b1; end
            m_lines++;
            m_lp = 0;
          end
          if (vr) begin
            e_valid = 1'b1;
            e_ok    = (m_lines == V) && !m_bad;
            e_crc   = crc_words(m_words);
            e_idx   = e_idx + 16'd1;
            e_lc    = (m_lines > V + 1) ? V + 1 : m_lines;
            if (m_lines != V) set_v = 1'b1;
            m_words.delete(); m_lines = 0; m_bad = 1'b0; m_lp = 0;
          end
          if (!rdn) begin
            m_words.push_back(pix);
            m_lp++;
          end
        end
        m_pv = vs;
        m_pr = rdn;
      end
      e_hpix  = set_h ? 1'b1 : (err_clr ? 1'b0 : e_hpix);
      e_vline = set_v ? 1'b1 : (err_clr ? 1'b0 : e_vline);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_bundle();
    return 64'({frame_valid, frame_ok, frame_crc, frame_idx, line_cnt, err_hpix, err_vline});
  endfunction

  task automatic cmp();
    logic [63:0] e;
    e = 64'({e_valid, e_ok, e_crc, e_idx, LW'(e_lc), e_hpix, e_vline});
    check("cycle{valid,ok,crc,idx,lines,hpix,vline}", dut_bundle(), e);
    if (frame_valid === 1'b1) vcnt++;
  endtask

  task automatic step();
    @(negedge clk);
    cmp();
  endtask

  task automatic sample_first(input logic v, input logic r, input logic [PW-1:0] p);
    vs = v; rdn = r; pix = p; pix_en = 1'b1;
    err_clr = rand_clr && ($urandom_range(0, 7) == 0);
    step();
  endtask

  task automatic sample_rest();
    pix_en = 1'b0; err_clr = 1'b0;
    repeat (3) step();
  endtask

  task automatic smp(input logic v, input logic r, input logic [PW-1:0] p);
    sample_first(v, r, p);
    sample_rest();
  endtask

  task automatic line_px(input int n, input logic [PW-1:0] val);
    for (int k = 0; k < n; k++) smp(1'b0, 1'b0, val);
    smp(1'b0, 1'b1, '0);
  endtask

  task automatic vs_pulse();
    smp(1'b1, 1'b1, '0);
    smp(1'b0, 1'b1, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [PW-1:0] z8[$];
    logic [PW-1:0] wa[$];
    logic [PW-1:0] wb[$];
    bit            bq[$];
    string         s;
    byte           ch;
    int            v0, mode, nl, np;

    // pin the model CRC to the CRC-16/CCITT-FALSE check value
    s = "123456789";
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      for (int k = 7; k >= 0; k--) bq.push_back(ch[k]);
    end
    check("model_crc_check_value", 64'(crc_bits(bq)), 64'h29B1);
    for (int i = 0; i < 8; i++) z8.push_back('0);

    repeat (3) step();
    check("reset_outputs_zero", dut_bundle(), 64'h0);
    rstn = 1'b1;
    repeat (2) step();

    // normal frames
    vs_pulse();
    v0 = vcnt;
    line_px(H, '0); line_px(H, '0);
    vs_pulse();
    check("normal_valid_pulses", 64'(vcnt - v0), 64'd1);
    check("normal_ok", 64'(frame_ok), 64'd1);
    check("normal_line_cnt", 64'(line_cnt), 64'd2);
    check("normal_idx", 64'(frame_idx), 64'd1);
    check("normal_crc", 64'(frame_crc), 64'(crc_words(z8)));
    line_px(H, '0); line_px(H, '0);
    vs_pulse();
    check("normal2_crc", 64'(frame_crc), 64'(crc_words(z8)));
    check("normal2_idx", 64'(frame_idx), 64'd2);

    // long line
    for (int k = 0; k < 5; k++) smp(1'b0, 1'b0, 12'h0A5);
    sample_first(1'b0, 1'b1, '0);
    check("long_hpix_next_cycle", 64'(err_hpix), 64'd1);
    sample_rest();
    line_px(H, 12'h05A);
    vs_pulse();
    check("long_frame_ok", 64'(frame_ok), 64'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    line_px(H, 12'h333); line_px(H, 12'h444);
    vs_pulse();
    check("after_clr_ok", 64'(frame_ok), 64'd1);
    check("after_clr_hpix", 64'(err_hpix), 64'd0);

    // missing line
    line_px(H, 12'h777);
    vs_pulse();
    check("missing_vline", 64'(err_vline), 64'd1);
    check("missing_line_cnt", 64'(line_cnt), 64'd1);
    check("missing_ok", 64'(frame_ok), 64'd0);

    // vs rise together with an accepted pixel
    wa = '{12'h123, 12'h123, 12'h123, 12'h123, 12'h456, 12'h456, 12'h456, 12'h456};
    wb = '{12'hFFF, 12'h789, 12'h789, 12'h789, 12'hABC, 12'hABC, 12'hABC, 12'hABC};
    line_px(H, 12'h123); line_px(H, 12'h456);
    smp(1'b1, 1'b0, 12'hFFF);
    check("simul_old_crc", 64'(frame_crc), 64'(crc_words(wa)));
    line_px(H - 1, 12'h789); line_px(H, 12'hABC);
    vs_pulse();
    check("simul_new_crc", 64'(frame_crc), 64'(crc_words(wb)));
    check("simul_new_ok", 64'(frame_ok), 64'd1);

    // reset in the middle of a line
    for (int k = 0; k < 3; k++) smp(1'b0, 1'b0, 12'h111);
    rstn = 1'b0;
    #1;
    check("midreset_outputs_zero", dut_bundle(), 64'h0);
    repeat (3) step();
    rstn = 1'b1;
    smp(1'b0, 1'b1, '0);
    v0 = vcnt;
    vs_pulse();
    check("midreset_no_pulse", 64'(vcnt - v0), 64'd0);
    line_px(H, 12'h222); line_px(H, 12'h222);
    vs_pulse();
    check("midreset_idx", 64'(frame_idx), 64'd1);

    // frame index wrap
    force dut.frame_idx_q = 16'hFFFF;
    idx_override = 1'b1;
    step();
    release dut.frame_idx_q;
    idx_override = 1'b0;
    line_px(H, 12'h999); line_px(H, 12'h999);
    vs_pulse();
    check("wrap_idx", 64'(frame_idx), 64'd0);

    // randomized frames, including open lines and coincident vs/pixel
    rand_clr = 1'b1;
    for (int f = 0; f < 40; f++) begin
      mode = int'($urandom_range(0, 5));
      nl   = int'($urandom_range(1, 3));
      for (int l = 0; l < nl; l++) begin
        np = int'($urandom_range(3, 5));
        for (int k = 0; k < np; k++) smp(1'b0, 1'b0, PW'($urandom));
        if (!((l == nl - 1) && (mode == 1 || mode == 2))) smp(1'b0, 1'b1, '0);
      end
      if (mode == 0 || mode == 2) begin
        smp(1'b1, 1'b0, PW'($urandom));
      end else begin
        vs_pulse();
      end
    end
    rand_clr = 1'b0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
